// File: rtl/montgomery_pkg.sv
// ---------------------------------------------------------------------------
// montgomery_pkg
// Shared definitions for the Montgomery-domain encoder.
//   DEFAULT_DATA_WIDTH : default operand / modulus width in bits
//   state_t            : encoder FSM state encoding (IDLE, PRE, SHIFT, DONE)
// ---------------------------------------------------------------------------
package montgomery_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRE   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : montgomery_pkg

// File: rtl/mont_dbl_sub.sv
// ---------------------------------------------------------------------------
// mont_dbl_sub
// One modular doubling step: acc_next = (2*acc >= n) ? 2*acc - n : 2*acc.
// Purely combinational.
//   acc      in  [DATA_WIDTH:0]   current residue, expected < n
//   n        in  [DATA_WIDTH-1:0] modulus
//   acc_next out [DATA_WIDTH:0]   doubled residue reduced once by n
// ---------------------------------------------------------------------------
module mont_dbl_sub #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH:0]   acc,
   input  logic [DATA_WIDTH-1:0] n,
   output logic [DATA_WIDTH:0]   acc_next
);

   logic [DATA_WIDTH:0] t;
   logic [DATA_WIDTH:0] n_ext;

   // With acc < n < 2^DATA_WIDTH the doubled value fits in DATA_WIDTH+1
   // bits, and a single conditional subtraction brings it back below n.
   always_comb begin
      n_ext    = {1'b0, n};
      t        = acc << 1;
      acc_next = (t >= n_ext) ? (t - n_ext) : t;
   end

endmodule : mont_dbl_sub

// File: rtl/montgomery_encode.sv
// ---------------------------------------------------------------------------
// montgomery_encode
// Converts x into the Montgomery domain: out = x * 2^k mod N, computed
// sequentially (reduce x below N, then k modular doublings).
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in_valid / in_ready  request handshake; in_ready is high only in IDLE
//   x, modulant          operand and modulus N, latched on acceptance
//   bit_length           k, the exponent of R = 2^k, latched on acceptance
//   out_valid/out_ready  result handshake; result held until out_ready
//   out, err             result and N==0 flag; both zero unless out_valid
//   dbg_state            current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer keeps data stable while valid is high and ready
// is low.
// ---------------------------------------------------------------------------
module montgomery_encode
   import montgomery_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] modulant,
   input  logic [DATA_WIDTH-1:0] bit_length,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  err,
   output state_t                dbg_state
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0] n_q, n_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH:0]   dbl_acc;
   logic [DATA_WIDTH:0]   n_ext;

   assign n_ext = {1'b0, n_q};

   mont_dbl_sub #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_dbl (
      .acc      (acc_q),
      .n        (n_q),
      .acc_next (dbl_acc)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = {1'b0, x};
               n_d     = modulant;
               cnt_d   = bit_length;
               state_d = PRE;
            end
         end
         PRE: begin
            // Bring x below N by repeated subtraction (one per cycle) so the
            // doubling step always starts from a proper residue.
            if (n_q == '0) begin
               acc_d   = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else if (acc_q >= n_ext) begin
               acc_d = acc_q - n_ext;
            end else if (cnt_q != '0) begin
               state_d = SHIFT;
            end else begin
               state_d = DONE;
            end
         end
         SHIFT: begin
            // cnt_q is never zero here: PRE only enters SHIFT with cnt != 0
            // and SHIFT leaves on the step that consumes the last count.
            acc_d = dbl_acc;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DATA_WIDTH'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Result outputs are gated so they read as zero outside DONE.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      out       = out_valid ? acc_q[DATA_WIDTH-1:0] : '0;
      err       = out_valid ? err_q : 1'b0;
      dbg_state = state_q;
   end

endmodule : montgomery_encode

// File: tb/tb_montgomery_encode.sv
// ---------------------------------------------------------------------------
// tb_montgomery_encode
// Self-checking bench for montgomery_encode (DATA_WIDTH = 8). Directed
// cases plus randomized requests, checked against an arithmetic reference
// model of x * 2^k mod N and of the expected request-to-result latency.
// ---------------------------------------------------------------------------
module tb_montgomery_encode;
   import montgomery_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] modulant;
   logic [W-1:0] bit_length;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         err;
   state_t       dbg_state;

   int n_checks;
   int n_pass;

   logic [W-1:0] exp_q[$];
   logic         exp_err_q[$];

   montgomery_encode #(
      .DATA_WIDTH (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x          (x),
      .modulant   (modulant),
      .bit_length (bit_length),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Result is x * 2^k mod N; latency counts the accepting cycle as 1, then
   // one reduction cycle per whole multiple of N in x, one final PRE cycle,
   // and k doubling cycles.
   function automatic void ref_model(input int xv, input int nv, input int kv,
                                     output int r, output int e, output int lat);
      longint prod;
      if (nv == 0) begin
         r   = 0;
         e   = 1;
         lat = 2;
      end else begin
         prod = longint'(xv) << kv;
         r    = int'(prod % longint'(nv));
         e    = 0;
         lat  = 2 + (xv / nv) + kv;
      end
   endfunction

   // ---------------- driver ----------------
   task automatic run_txn(input int xv, input int nv, input int kv, input int hold);
      int           r, e, lat_exp, lat;
      logic [W-1:0] exp_out;
      logic         exp_err;
      logic [W-1:0] o_hold;
      logic         e_hold;
      ref_model(xv, nv, kv, r, e, lat_exp);
      exp_q.push_back(W'(r));
      exp_err_q.push_back(e[0]);

      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      x          = W'(xv);
      modulant   = W'(nv);
      bit_length = W'(kv);
      @(posedge clk);
      #1;
      // Scramble operands after acceptance; they must be ignored.
      in_valid   = 1'b0;
      x          = W'($urandom);
      modulant   = W'($urandom);
      bit_length = W'($urandom);
      check("busy_outputs_zero", {22'd0, out_valid, err, out}, 32'd0);
      check("busy_in_ready", 32'(in_ready), 32'd0);

      lat = 1;
      while (!out_valid && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(lat_exp));
      exp_out = exp_q.pop_front();
      exp_err = exp_err_q.pop_front();
      if (!out_valid) return;
      check("out", 32'(out), 32'(exp_out));
      check("err", 32'(err), 32'(exp_err));

      o_hold = out;
      e_hold = err;
      for (int i = 0; i < hold; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         x          = W'($urandom);
         modulant   = W'($urandom);
         bit_length = W'($urandom);
         @(posedge clk);
         #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_out", 32'(out), 32'(o_hold));
         check("hold_err", 32'(err), 32'(e_hold));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_out_zero", {31'd0, err} | 32'(out), 32'd0);
   endtask

   task automatic reset_mid_shift();
      @(negedge clk);
      in_valid   = 1'b1;
      x          = 8'd5;
      modulant   = 8'd13;
      bit_length = 8'd4;
      @(posedge clk);          // accepted, now in PRE
      #1;
      in_valid = 1'b0;
      @(posedge clk);          // first SHIFT cycle
      #1;
      @(posedge clk);          // second SHIFT cycle
      #1;
      check("mid_shift_state", 32'(dbg_state), 32'(SHIFT));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int xv, nv, kv;
      n_checks   = 0;
      n_pass     = 0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      x          = '0;
      modulant   = '0;
      bit_length = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out", 32'(out), 32'd0);
      check("reset_err", 32'(err), 32'd0);

      // Directed cases.
      run_txn(5, 13, 4, 0);      // out 2, latency 6
      run_txn(12, 13, 4, 1);     // out 10
      run_txn(0, 13, 4, 0);      // out 0
      run_txn(200, 13, 8, 0);    // 15 reductions, out 6, latency 25
      run_txn(7, 0, 3, 2);       // N == 0 -> err
      run_txn(5, 13, 4, 3);      // recovery after err, backpressure
      run_txn(20, 13, 0, 0);     // k = 0 -> x mod N
      run_txn(255, 255, 1, 0);   // x == N boundary
      run_txn(254, 255, 7, 1);   // largest residue, widest doubling

      reset_mid_shift();
      run_txn(5, 13, 4, 0);

      // Randomized requests.
      for (int i = 0; i < 40; i++) begin
         xv = int'($urandom_range(0, 255));
         nv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
         kv = int'($urandom_range(0, 12));
         run_txn(xv, nv, kv, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_montgomery_encode

// File: doc/montgomery_encode.md
MONTGOMERY_ENCODE -- requirements
Module: montgomery_encode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving operand and modulus width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request carries a valid operand set.
REQ-005 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-006 SHALL have port x, input, DATA_WIDTH, value to convert into the Montgomery domain.
REQ-007 SHALL have port modulant, input, DATA_WIDTH, modulus N.
REQ-008 SHALL have port bit_length, input, DATA_WIDTH, exponent k, where R = 2^k.
REQ-009 SHALL have port out_valid, output, 1, result is valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port out, output, DATA_WIDTH, result x*2^k mod N.
REQ-012 SHALL have port err, output, 1, flag qualified by out_valid; set when modulant == 0.

Function
REQ-013 SHALL implement FSM states IDLE, PRE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready.
REQ-015 On acceptance, SHALL latch x into acc (DATA_WIDTH+1 bits), modulant into N_r, bit_length into cnt, and go to PRE; unaccepted cycles leave all registers unchanged.
REQ-016 Inputs x, modulant, bit_length SHALL be ignored outside the accepting cycle.
REQ-017 PRE, N_r == 0: acc <= 0, err <= 1, go to DONE.
REQ-018 PRE, acc >= N_r: acc <= acc - N_r, stay in PRE, one subtraction per cycle.
REQ-019 PRE, acc < N_r: go to SHIFT if cnt != 0, else go to DONE.
REQ-020 SHIFT, each cycle: t = acc << 1 (DATA_WIDTH+1 bits); acc <= (t >= N_r) ? t - N_r : t; cnt <= cnt - 1; go to DONE when cnt == 1.
REQ-021 acc SHALL stay < N_r after every SHIFT step, and the DATA_WIDTH+1-bit doubling SHALL never overflow.
REQ-022 DONE: out_valid = 1, out = acc[DATA_WIDTH-1:0], err as set; outputs stay stable until out_ready.
REQ-023 DONE with out_ready = 1: go to IDLE, clear err; in_ready rises the following cycle, giving no same-cycle turnaround.
REQ-024 Latency, acceptance at edge T with x < N and k >= 1: out_valid first high in cycle T+2+k; each extra PRE subtraction adds one cycle.
REQ-025 With k = 0, result SHALL be x mod N.
REQ-026 out and err SHALL be 0 whenever out_valid = 0.

Reset
REQ-027 reset SHALL force IDLE with acc = 0, cnt = 0, N_r = 0, err = 0, out_valid = 0, out = 0, in_ready = 1 on the next cycle.
REQ-028 reset SHALL take priority over every transition, including mid-PRE, mid-SHIFT and DONE with out_ready high; any in-flight result is discarded.

Structure
REQ-029 A shared package montgomery_pkg SHALL hold the FSM state enum (IDLE, PRE, SHIFT, DONE) and the default DATA_WIDTH constant.
REQ-030 The conditional doubling step (REQ-020) SHALL be a combinational sub-module mont_dbl_sub, parameterised by DATA_WIDTH, with inputs acc and N and output next acc.
REQ-031 The RTL SHALL use no combinational loop over bit_length; iteration is sequential only.

Verification
REQ-032 x=5, N=13, k=4, out_ready=1 -> out=2, err=0, out_valid first high 6 cycles after acceptance.
REQ-033 x=12, N=13, k=4 -> out=10; x=0, N=13, k=4 -> out=0.
REQ-034 x=200, N=13, k=8 -> 15 PRE cycles, then out=6, out_valid first high 25 cycles after acceptance.
REQ-035 N=0, x=7, k=3 -> out_valid with err=1, out=0; next request x=5, N=13, k=4 -> out=2, err=0.
REQ-036 Backpressure: out_ready low for 3 cycles in DONE -> out, out_valid, err stable; in_ready low; in_valid pulses ignored.
REQ-037 reset asserted during the second SHIFT cycle -> next cycle IDLE, in_ready=1, out_valid=0; a fresh request x=5, N=13, k=4 returns out=2.
